// File: rtl/gray_to_binary_decoder.sv
// Gray-to-binary decoder with one-word output register, valid/ready on
// both sides, single-step (Hamming distance) checking and error counter.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   gray_in, in_valid  upstream word and its valid
//   in_ready           upstream handshake (comb from out_ready only)
//   bin_out, out_valid decoded word and its valid
//   out_ready          downstream handshake
//   step_err           word differs from previous accepted word in >= 2 bits
//   repeat_flag        word equals previous accepted word
//   err_count          saturating count of accepted step errors
//   err_count_clr      synchronous clear of err_count (wins over increment)
module gray_to_binary_decoder #(
   parameter int SIZE  = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SIZE-1:0]  gray_in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [SIZE-1:0]  bin_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             step_err,
   output logic             repeat_flag,
   output logic [CNT_W-1:0] err_count,
   input  logic             err_count_clr
);

   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_TRACK = 1'b1;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [0:0]      state_q, state_d;
   logic [SIZE-1:0] last_gray_q, last_gray_d;
   logic [SIZE-1:0] bin_q, bin_d;
   logic            valid_q, valid_d;
   logic            step_q, step_d;
   logic            rep_q, rep_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic            accept;
   logic [SIZE-1:0] bin_c;
   logic [SIZE-1:0] diff;
   logic            dist_zero;
   logic            dist_multi;
   logic            step_c;
   logic            rep_c;

   assign in_ready = rst_n && (!valid_q || out_ready);
   assign accept   = in_valid && in_ready;

   // Prefix XOR from the MSB down.
   always_comb begin
      bin_c = '0;
      bin_c[SIZE-1] = gray_in[SIZE-1];
      for (int i = SIZE - 2; i >= 0; i--) begin
         bin_c[i] = bin_c[i+1] ^ gray_in[i];
      end
   end

   // Distance >= 2 iff clearing the lowest set bit still leaves a bit set.
   assign diff       = gray_in ^ last_gray_q;
   assign dist_zero  = (diff == '0);
   assign dist_multi = ((diff & (diff - 1'b1)) != '0);

   assign step_c = (state_q == ST_TRACK) && dist_multi;
   assign rep_c  = (state_q == ST_TRACK) && dist_zero;

   always_comb begin
      state_d     = state_q;
      last_gray_d = last_gray_q;
      bin_d       = bin_q;
      valid_d     = valid_q;
      step_d      = step_q;
      rep_d       = rep_q;
      cnt_d       = cnt_q;

      if (accept) begin
         state_d     = ST_TRACK;
         last_gray_d = gray_in;
         bin_d       = bin_c;
         valid_d     = 1'b1;
         step_d      = step_c;
         rep_d       = rep_c;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end

      if (err_count_clr) begin
         cnt_d = '0;
      end else if (accept && step_c && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         last_gray_q <= '0;
         bin_q       <= '0;
         valid_q     <= 1'b0;
         step_q      <= 1'b0;
         rep_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         last_gray_q <= last_gray_d;
         bin_q       <= bin_d;
         valid_q     <= valid_d;
         step_q      <= step_d;
         rep_q       <= rep_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bin_out     = bin_q;
   assign out_valid   = valid_q;
   assign step_err    = step_q;
   assign repeat_flag = rep_q;
   assign err_count   = cnt_q;

endmodule
